zero_count_stream: RTL and testbench
====================================

Name: zero_count_stream

Overview:
- Sequential, parametrised successor to the combinational zero-counter.
- Accepts a DATA_W-bit word over a valid/ready handshake and scans it CHUNK bits per clock.
- Counts either the zeros or the ones in the word; the choice is latched per word.
- Returns the count over a valid/ready output handshake.
- Sits between a word producer (register file, bus slave) and status logic that needs population counts without a wide single-cycle adder tree.

Parameters:
- DATA_W, 8: input word width; must be ≥ 1.
- CHUNK, 2: bits examined per clock; must be ≥ 1 and divide DATA_W exactly. Elaboration-time check fails otherwise.
- CNT_W, $clog2(DATA_W+1): count width; holds values 0..DATA_W.

Ports:
- clk, input, 1: single clock, rising-edge.
- rst_n, input, 1: asynchronous active-low reset.
- in_valid, input, 1: in_data/in_mode are valid.
- in_ready, output, 1: block can accept a word.
- in_data, input, DATA_W: word to scan.
- in_mode, input, 1: 0 = count zeros, 1 = count ones.
- out_valid, output, 1: out_count valid.
- out_ready, input, 1: consumer takes result.
- out_count, output, CNT_W: number of matching bits.
- out_all, output, 1: out_count == DATA_W (word is all-matching).
- busy, output, 1: scan in progress.

Behaviour:
- Clock/reset:
  - One clock, clk. Reset rst_n is asynchronous, active-low.
  - On rst_n=0, immediately: state=IDLE, in_ready=0 while rst_n=0 then 1 in IDLE, out_valid=0, out_count=0, out_all=0, busy=0. Internal shift register, chunk counter and mode register are cleared.
- States: IDLE, SCAN, DONE.
- IDLE:
  - in_ready=1.
  - Accept on the rising edge where in_valid && in_ready.
  - At accept: load in_data into the shift register, latch in_mode, clear the accumulator and chunk counter, go to SCAN.
  - in_valid with in_ready=0 is ignored. The producer must hold the word stable until accepted.
- SCAN:
  - in_ready=0, busy=1.
  - Each cycle: add the number of bits in shreg[CHUNK-1:0] equal to the latched match value (match = in_mode) to the accumulator, shift right by CHUNK, increment the chunk counter.
  - After exactly N = DATA_W/CHUNK SCAN cycles, go to DONE and register out_count plus out_all.
  - out_valid rises on the N-th clock edge after the accept edge. Example: DATA_W=8, CHUNK=2 gives 4 cycles.
- DONE:
  - out_valid=1, busy=0, in_ready=0.
  - out_count and out_all are held stable while out_valid && !out_ready (back-pressure of any length).
  - On the edge with out_ready=1: go to IDLE, clear out_valid. out_count keeps its last value but is don't-care when out_valid=0.
- Arithmetic:
  - Accumulator is CNT_W bits and never overflows (max DATA_W).
  - Per-chunk add is zero-extended to CNT_W.
- Mid-operation input changes:
  - in_data/in_mode changes during SCAN/DONE have no effect; values are latched at accept.
  - Reset during SCAN or DONE aborts the word. No output is produced for it. The block returns to IDLE and accepts a new word on the first edge after rst_n deasserts.
- Throughput: one word per N+2 cycles, minimum (accept, N scans, handshake out). No overlap of input and output transactions.
- Degenerate case CHUNK=DATA_W: N=1; out_valid one cycle after accept.
- Generalisation: CHUNK=1 is a pure serial counter.

Test Plan:
- DATA_W=8, CHUNK=2: in_data=8'h00, mode=0, out_ready=1 → out_valid exactly 4 cycles after accept, out_count=8, out_all=1; then in_ready=1 the following cycle.
- DATA_W=8, CHUNK=2: 8'hA5 with mode=0 → count=4. Then 8'hA5 with mode=1 → count=4. Then 8'hFE with mode=0 → count=1, out_all=0. Then 8'hFF with mode=1 → count=8, out_all=1.
- Back-pressure: hold out_ready=0 for 10 cycles after out_valid.
  - out_valid, out_count and out_all stay stable.
  - in_ready stays 0 and a pending in_valid word is not taken.
  - Once out_ready=1, the pending word is accepted the cycle after IDLE is re-entered.
- Reset mid-scan: assert rst_n=0 two cycles after accepting 8'h0F.
  - All outputs go to reset values immediately.
  - No out_valid pulse for that word.
  - Next word 8'h0F with mode=0 → count=4.
- DATA_W=16, CHUNK=1: 16'h8001 with mode=1 → out_valid 16 cycles after accept, count=2. Random 200 words with random mode and out_ready compared against a reference popcount model.
- DATA_W=8, CHUNK=8: 8'h3C with mode=0 → out_valid 1 cycle after accept, count=4.

Source files
------------

// File: rtl/zero_count_stream.sv
// Streaming population counter: takes a word over valid/ready, scans it CHUNK bits
// per clock, and returns the number of zeros or ones over a valid/ready output.
`timescale 1ns/1ps
module zero_count_stream #(
  parameter int DATA_W = 8,
  parameter int CHUNK  = 2,
  parameter int CNT_W  = $clog2(DATA_W + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_mode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CNT_W-1:0]  out_count,
  output logic              out_all,
  output logic              busy
);

  localparam int N     = (CHUNK > 0) ? DATA_W / CHUNK : 1;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  generate
    if (DATA_W < 1 || CHUNK < 1 || (DATA_W % CHUNK) != 0) begin : g_bad_params
      $error("zero_count_stream: CHUNK must be >= 1 and divide DATA_W exactly");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, SCAN, DONE} state_e;

  state_e              state_q, state_d;
  logic [DATA_W-1:0]   shreg_q, shreg_d;
  logic                mode_q, mode_d;
  logic [IDX_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                all_q, all_d;
  logic [CNT_W-1:0]    chunk_hits;

  // Matching bits in the low chunk; each hit is zero-extended before summing.
  always_comb begin
    chunk_hits = '0;
    for (int i = 0; i < CHUNK; i++) begin
      chunk_hits = chunk_hits + CNT_W'(shreg_q[i] ~^ mode_q);
    end
  end

  // NOTE: every _d gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    count_d = count_q;
    all_d   = all_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          shreg_d = in_data;
          mode_d  = in_mode;
          cnt_d   = '0;
          acc_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        acc_d   = acc_q + chunk_hits;
        shreg_d = shreg_q >> CHUNK;
        cnt_d   = cnt_q + IDX_W'(1);
        if (cnt_q == IDX_W'(N - 1)) begin
          state_d = DONE;
          count_d = acc_d;
          all_d   = (acc_d == CNT_W'(DATA_W));
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shreg_q <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      count_q <= '0;
      all_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      all_q   <= all_d;
    end
  end

  // in_ready is gated by rst_n so it drops immediately while reset is held.
  assign in_ready  = rst_n && (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == SCAN);
  assign out_count = count_q;
  assign out_all   = all_q;

endmodule

// File: tb/tb_zero_count_stream.sv
// Self-checking bench: three configurations (8/2, 16/1, 8/8) against a popcount model.
`timescale 1ns/1ps
module tb_zero_count_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // DUT A: DATA_W=8, CHUNK=2
  logic       a_in_valid, a_in_ready, a_in_mode, a_out_valid, a_out_ready, a_out_all, a_busy;
  logic [7:0] a_in_data;
  logic [3:0] a_out_count;
  // DUT B: DATA_W=16, CHUNK=1
  logic        b_in_valid, b_in_ready, b_in_mode, b_out_valid, b_out_ready, b_out_all, b_busy;
  logic [15:0] b_in_data;
  logic [4:0]  b_out_count;
  // DUT C: DATA_W=8, CHUNK=8
  logic       c_in_valid, c_in_ready, c_in_mode, c_out_valid, c_out_ready, c_out_all, c_busy;
  logic [7:0] c_in_data;
  logic [3:0] c_out_count;

  zero_count_stream #(.DATA_W(8), .CHUNK(2)) u_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data), .in_mode(a_in_mode),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_count(a_out_count),
    .out_all(a_out_all), .busy(a_busy)
  );

  zero_count_stream #(.DATA_W(16), .CHUNK(1)) u_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data), .in_mode(b_in_mode),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_count(b_out_count),
    .out_all(b_out_all), .busy(b_busy)
  );

  zero_count_stream #(.DATA_W(8), .CHUNK(8)) u_c (
    .clk(clk), .rst_n(rst_n),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_data(c_in_data), .in_mode(c_in_mode),
    .out_valid(c_out_valid), .out_ready(c_out_ready), .out_count(c_out_count),
    .out_all(c_out_all), .busy(c_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: count bits of the low w bits of d that equal m.
  function automatic int ref_count(input logic [15:0] d, input int w, input logic m);
    int c = 0;
    for (int i = 0; i < w; i++) if (d[i] == m) c++;
    return c;
  endfunction

  // One word through DUT A with out_ready held high.
  task automatic a_word(input logic [7:0] d, input logic m);
    int k;
    int g;
    int exp;
    g = 0;
    while (!a_in_ready && g < 50) begin @(negedge clk); g++; end
    a_in_data = d; a_in_mode = m; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0; a_in_data = ~d; a_in_mode = ~m;
    check("a_busy_scan", a_busy, 1);
    k = 0;
    while (!a_out_valid && k < 100) begin @(negedge clk); k++; end
    exp = ref_count({8'h00, d}, 8, m);
    check("a_latency", k, 4);
    check("a_count", a_out_count, exp);
    check("a_all", a_out_all, (exp == 8) ? 1 : 0);
    check("a_busy_done", a_busy, 0);
    @(negedge clk);
    check("a_valid_drop", a_out_valid, 0);
    check("a_ready_back", a_in_ready, 1);
  endtask

  // One word through DUT B with `hold` cycles of back-pressure.
  task automatic b_word(input logic [15:0] d, input logic m, input int hold);
    int k;
    int g;
    int exp;
    g = 0;
    while (!b_in_ready && g < 50) begin @(negedge clk); g++; end
    check("b_in_ready", b_in_ready, 1);
    b_out_ready = 1'b0;
    b_in_data = d; b_in_mode = m; b_in_valid = 1'b1;
    @(negedge clk);
    b_in_valid = 1'b0; b_in_data = 16'($urandom); b_in_mode = 1'($urandom);
    k = 0;
    while (!b_out_valid && k < 100) begin @(negedge clk); k++; end
    exp = ref_count(d, 16, m);
    check("b_latency", k, 16);
    check("b_count", b_out_count, exp);
    check("b_all", b_out_all, (exp == 16) ? 1 : 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check("b_hold_valid", b_out_valid, 1);
      check("b_hold_count", b_out_count, exp);
    end
    b_out_ready = 1'b1;
    @(negedge clk);
    check("b_valid_drop", b_out_valid, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int k;
    int g;
    logic seen;
    logic [15:0] rd;

    rst_n = 1'b0;
    a_in_valid = 0; a_in_data = '0; a_in_mode = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_in_mode = 0; b_out_ready = 1;
    c_in_valid = 0; c_in_data = '0; c_in_mode = 0; c_out_ready = 1;
    #1;
    check("rst_in_ready", a_in_ready, 0);
    check("rst_out_valid", a_out_valid, 0);
    check("rst_out_count", a_out_count, 0);
    check("rst_out_all", a_out_all, 0);
    check("rst_busy", a_busy, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("idle_in_ready", a_in_ready, 1);

    // Directed words on the 8/2 configuration.
    a_word(8'h00, 1'b0);
    a_word(8'hA5, 1'b0);
    a_word(8'hA5, 1'b1);
    a_word(8'hFE, 1'b0);
    a_word(8'hFF, 1'b1);

    // Back-pressure with a pending word waiting on the input.
    a_out_ready = 1'b0;
    a_in_data = 8'h3C; a_in_mode = 1'b1; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    k = 0;
    while (!a_out_valid && k < 100) begin @(negedge clk); k++; end
    check("bp_latency", k, 4);
    a_in_data = 8'h81; a_in_mode = 1'b0; a_in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_valid", a_out_valid, 1);
      check("bp_count", a_out_count, 4);
      check("bp_all", a_out_all, 0);
      check("bp_in_ready", a_in_ready, 0);
    end
    a_out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_valid", a_out_valid, 0);
    check("bp_release_ready", a_in_ready, 1);
    @(negedge clk);
    a_in_valid = 1'b0;
    check("bp_pending_taken", a_busy, 1);
    k = 0;
    while (!a_out_valid && k < 100) begin @(negedge clk); k++; end
    check("bp_pending_latency", k, 4);
    check("bp_pending_count", a_out_count, ref_count(16'h0081, 8, 1'b0));
    @(negedge clk);

    // Reset two cycles after accepting a word: no result may appear.
    a_in_data = 8'h0F; a_in_mode = 1'b0; a_in_valid = 1'b1;
    @(negedge clk);
    a_in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_busy", a_busy, 0);
    check("mid_rst_valid", a_out_valid, 0);
    check("mid_rst_ready", a_in_ready, 0);
    check("mid_rst_count", a_out_count, 0);
    check("mid_rst_all", a_out_all, 0);
    seen = 1'b0;
    repeat (2) begin @(negedge clk); seen = seen | a_out_valid; end
    rst_n = 1'b1;
    repeat (8) begin @(negedge clk); seen = seen | a_out_valid; end
    check("mid_rst_no_output", seen, 0);
    a_word(8'h0F, 1'b0);

    // Degenerate CHUNK=DATA_W configuration.
    g = 0;
    while (!c_in_ready && g < 50) begin @(negedge clk); g++; end
    c_in_data = 8'h3C; c_in_mode = 1'b0; c_in_valid = 1'b1;
    @(negedge clk);
    c_in_valid = 1'b0; c_in_data = 8'hFF;
    k = 0;
    while (!c_out_valid && k < 100) begin @(negedge clk); k++; end
    check("c_latency", k, 1);
    check("c_count", c_out_count, 4);
    check("c_all", c_out_all, 0);
    @(negedge clk);
    check("c_ready_back", c_in_ready, 1);

    // Serial configuration: directed word then randomized words.
    b_word(16'h8001, 1'b1, 0);
    for (int n = 0; n < 200; n++) begin
      case ($urandom_range(0, 7))
        0:       rd = 16'h0000;
        1:       rd = 16'hFFFF;
        default: rd = 16'($urandom);
      endcase
      b_word(rd, 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
